// File: rtl/seq_detector_param_if.sv
// Serial pattern-detector bus: data/control inputs plus match flag, armed status and match count.
// master drives the stream and controls; slave is the detector.
interface seq_detector_param_if #(
    parameter int PAT_LEN   = 4,
    parameter int CNT_WIDTH = 8
);
    logic                 i;
    logic                 i_valid;
    logic                 overlap;
    logic                 pat_load;
    logic [PAT_LEN-1:0]   pat_in;
    logic                 cnt_clr;
    logic                 o;
    logic                 armed;
    logic [CNT_WIDTH-1:0] match_count;

    modport master (
        output i, i_valid, overlap, pat_load, pat_in, cnt_clr,
        input  o, armed, match_count
    );

    modport slave (
        input  i, i_valid, overlap, pat_load, pat_in, cnt_clr,
        output o, armed, match_count
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parameterised serial pattern detector, Mealy match flag with zero latency from i to o.
// No backpressure: a bit is consumed on every edge with i_valid=1 unless pat_load or rst is high.
module seq_detector_param #(
    parameter int                 PAT_LEN     = 4,
    parameter logic [PAT_LEN-1:0] PAT_DEFAULT = 4'b1101,
    parameter int                 CNT_WIDTH   = 8
) (
    input  logic               clk,
    input  logic               rst,
    seq_detector_param_if.slave bus
);
    localparam int HW = PAT_LEN - 1;
    localparam int FW = $clog2(PAT_LEN);
    localparam logic [FW-1:0]        FILL_FULL = FW'(PAT_LEN - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    typedef enum logic {FILLING, ARMED} state_t;

    state_t               state, state_nxt;
    logic [FW-1:0]        fill, fill_nxt;
    logic [HW-1:0]        hist, hist_nxt;
    logic [PAT_LEN-1:0]   pat, pat_nxt;
    logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

    logic consume;
    logic hit;

    // A bit presented alongside a pattern load (or reset) is dropped, never matched.
    assign consume = bus.i_valid & ~bus.pat_load & ~rst;
    assign hit     = consume & (state == ARMED) & ({hist, bus.i} == pat);

    assign bus.o           = hit;
    assign bus.armed       = (state == ARMED);
    assign bus.match_count = cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILLING;
            fill  <= '0;
            hist  <= '0;
            pat   <= PAT_DEFAULT;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            fill  <= fill_nxt;
            hist  <= hist_nxt;
            pat   <= pat_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        fill_nxt  = fill;
        hist_nxt  = hist;
        pat_nxt   = pat;
        cnt_nxt   = cnt;

        if (bus.pat_load) begin
            pat_nxt   = bus.pat_in;
            hist_nxt  = '0;
            fill_nxt  = '0;
            state_nxt = FILLING;
        end else if (consume) begin
            if (hit && !bus.overlap) begin
                // Non-overlapping: the matching bit must not seed the next match.
                hist_nxt  = '0;
                fill_nxt  = '0;
                state_nxt = FILLING;
            end else begin
                hist_nxt = HW'({hist, bus.i});
                if (fill != FILL_FULL)
                    fill_nxt = fill + FW'(1);
                state_nxt = (fill_nxt == FILL_FULL) ? ARMED : FILLING;
            end
        end

        if (bus.cnt_clr)
            cnt_nxt = '0;
        else if (hit && (cnt != CNT_MAX))
            cnt_nxt = cnt + CNT_WIDTH'(1);
    end
endmodule
